// File: rtl/cpu_ctrl_pkg.sv
// Shared controller state encoding; also consumed by the 7-segment mux to display state.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_BRK  = 2'd3
  } cpu_state_e;

endpackage

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// Step button conditioner: 2-flop synchronizer, stability counter and a one-cycle
// pulse on each accepted press.
module btn_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk_in,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic             s1_q, s2_q;
  logic             stable_q;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q;

  // A new level is accepted after DB_CYCLES consecutive samples that differ from
  // the accepted level; only the low-to-high acceptance produces a pulse.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q    <= btn_raw;
      s2_q    <= s1_q;
      pulse_q <= 1'b0;
      if (s2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        stable_q <= s2_q;
        pulse_q  <= s2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint controller producing a one-cycle CPU clock-enable in the
// clk_in domain, with stall hold-off and a retired-instruction counter.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DIV       = 10000000,
  parameter int DB_CYCLES = 1000000,
  parameter int PC_W      = 32
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic            run_sw,
  input  logic            step_btn,
  input  logic            bp_en,
  input  logic [PC_W-1:0] bp_addr,
  input  logic [PC_W-1:0] pc,
  input  logic            cpu_stall,
  output logic            cpu_ce,
  output logic [1:0]      state,
  output logic            halted,
  output logic [31:0]     inst_cnt
);

  localparam int TICK_W = $clog2(DIV);

  cpu_state_e        state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              pending_q, pending_d;
  logic              bp_skip_q, bp_skip_d;
  logic              ce_q, ce_d;
  logic              halted_q;
  logic [31:0]       inst_cnt_q;
  logic              step_pulse;
  logic              fire, bp_hit, wrap;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_step_db (
    .clk_in  (clk_in),
    .reset   (reset),
    .btn_raw (step_btn),
    .pulse   (step_pulse)
  );

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    pending_d = pending_q;
    bp_skip_d = bp_skip_q;
    ce_d      = 1'b0;
    fire      = pending_q & ~cpu_stall;
    bp_hit    = bp_en & (pc == bp_addr) & ~bp_skip_q;
    wrap      = (tick_q == TICK_W'(DIV - 1));
    case (state_q)
      ST_IDLE: begin
        if (run_sw) begin
          state_d   = ST_RUN;
          tick_d    = '0;
          pending_d = 1'b0;
        end else if (step_pulse) begin
          state_d   = ST_STEP;
          pending_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (!run_sw) begin
          state_d   = ST_IDLE;
          pending_d = 1'b0;
        end else begin
          tick_d = wrap ? '0 : tick_q + TICK_W'(1);
          if (wrap) pending_d = 1'b1;
          // A fresh tick landing on the issue cycle re-arms pending; a hit discards it.
          if (fire) begin
            if (bp_hit) begin
              state_d   = ST_BRK;
              pending_d = 1'b0;
            end else begin
              ce_d      = 1'b1;
              bp_skip_d = 1'b0;
              if (!wrap) pending_d = 1'b0;
            end
          end
        end
      end
      ST_STEP: begin
        if (fire) begin
          ce_d      = 1'b1;
          pending_d = 1'b0;
          bp_skip_d = 1'b0;
          tick_d    = '0;
          state_d   = run_sw ? ST_RUN : ST_IDLE;
        end
      end
      ST_BRK: begin
        pending_d = 1'b0;
        if (step_pulse) begin
          state_d   = ST_STEP;
          pending_d = 1'b1;
          bp_skip_d = 1'b1;
        end else if (!run_sw) begin
          state_d   = ST_IDLE;
          bp_skip_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      pending_q  <= 1'b0;
      bp_skip_q  <= 1'b0;
      ce_q       <= 1'b0;
      halted_q   <= 1'b1;
      inst_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      pending_q  <= pending_d;
      bp_skip_q  <= bp_skip_d;
      ce_q       <= ce_d;
      halted_q   <= (state_d == ST_IDLE) || (state_d == ST_BRK);
      if (ce_d) inst_cnt_q <= inst_cnt_q + 32'd1;
    end
  end

  assign cpu_ce   = ce_q;
  assign state    = state_q;
  assign halted   = halted_q;
  assign inst_cnt = inst_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with DIV=4, DB_CYCLES=3; expected values are
// hand-derived cycle counts from each step.
module tb_cpu_run_ctrl;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        run_sw;
  logic        step_btn;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        cpu_stall;
  logic        cpu_ce;
  logic [1:0]  state;
  logic        halted;
  logic [31:0] inst_cnt;

  int n_checks = 0;
  int n_fails  = 0;
  int ce_seen  = 0;
  int base;

  cpu_run_ctrl #(
    .DIV       (4),
    .DB_CYCLES (3),
    .PC_W      (32)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .run_sw    (run_sw),
    .step_btn  (step_btn),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .pc        (pc),
    .cpu_stall (cpu_stall),
    .cpu_ce    (cpu_ce),
    .state     (state),
    .halted    (halted),
    .inst_cnt  (inst_cnt)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) if (cpu_ce === 1'b1) ce_seen++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic pat [14];

  initial begin
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
            1'b0, 1'b0, 1'b0, 1'b0};
    reset = 1'b0; run_sw = 1'b0; step_btn = 1'b0; bp_en = 1'b0;
    bp_addr = 32'h0000_0010; pc = 32'h0; cpu_stall = 1'b0;

    // reset values
    tick(3);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ce", 32'(cpu_ce), 32'd0);
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_cnt", inst_cnt, 32'd0);

    // continuous run: first ce DIV+1 after entry, then every DIV
    reset = 1'b1; run_sw = 1'b1;
    tick(1);
    chk("run_state", 32'(state), 32'd1);
    chk("run_halted", 32'(halted), 32'd0);
    tick(4);
    chk("run_ce_early", 32'(cpu_ce), 32'd0);
    tick(1);
    chk("run_ce1", 32'(cpu_ce), 32'd1);
    chk("run_cnt1", inst_cnt, 32'd1);
    tick(4);
    chk("run_ce2", 32'(cpu_ce), 32'd1);
    tick(4);
    chk("run_ce3", 32'(cpu_ce), 32'd1);
    chk("run_cnt3", inst_cnt, 32'd3);
    run_sw = 1'b0;
    tick(1);
    chk("halt_state", 32'(state), 32'd0);
    chk("halt_halted", 32'(halted), 32'd1);

    // bouncing press from IDLE: one step
    base = ce_seen;
    for (int i = 0; i < 14; i++) begin
      step_btn = pat[i];
      tick(1);
      if (i == 7) chk("step_enter", 32'(state), 32'd2);
      if (i == 8) begin
        chk("step_ce", 32'(cpu_ce), 32'd1);
        chk("step_back_idle", 32'(state), 32'd0);
        chk("step_cnt", inst_cnt, 32'd4);
      end
    end
    step_btn = 1'b0;
    tick(8);
    chk("step_one_ce", 32'(ce_seen - base), 32'd1);
    chk("step_idle", 32'(state), 32'd0);

    // stall held 9 cycles starting at a tick
    run_sw = 1'b1;
    tick(1);
    chk("stall_run", 32'(state), 32'd1);
    tick(3);
    cpu_stall = 1'b1;
    base = ce_seen;
    tick(9);
    chk("stall_no_ce", 32'(ce_seen - base), 32'd0);
    cpu_stall = 1'b0;
    tick(1);
    chk("stall_release_ce", 32'(cpu_ce), 32'd1);
    chk("stall_cnt", inst_cnt, 32'd5);
    tick(3);
    chk("stall_dropped", inst_cnt, 32'd5);
    tick(1);
    chk("post_stall_ce", 32'(cpu_ce), 32'd1);
    chk("post_stall_cnt", inst_cnt, 32'd6);

    // breakpoint hit in RUN
    bp_en = 1'b1; pc = 32'h0000_0010;
    tick(4);
    chk("bp_state", 32'(state), 32'd3);
    chk("bp_halted", 32'(halted), 32'd1);
    chk("bp_no_ce", 32'(cpu_ce), 32'd0);
    chk("bp_cnt", inst_cnt, 32'd6);
    cpu_stall = 1'b1;
    tick(5);
    chk("bp_hold", 32'(state), 32'd3);
    chk("bp_hold_cnt", inst_cnt, 32'd6);
    cpu_stall = 1'b0;

    // step out of BRK past the breakpoint, then hit again
    step_btn = 1'b1;
    tick(6);
    chk("bpstep_enter", 32'(state), 32'd2);
    tick(1);
    chk("bpstep_ce", 32'(cpu_ce), 32'd1);
    chk("bpstep_run", 32'(state), 32'd1);
    chk("bpstep_cnt", inst_cnt, 32'd7);
    tick(1);
    step_btn = 1'b0;
    tick(4);
    chk("bp_again", 32'(state), 32'd3);
    chk("bp_again_cnt", inst_cnt, 32'd7);

    // BRK -> IDLE -> RUN resumes past the breakpoint once
    run_sw = 1'b0;
    tick(1);
    chk("brk_idle", 32'(state), 32'd0);
    chk("brk_idle_halted", 32'(halted), 32'd1);
    run_sw = 1'b1;
    tick(1);
    chk("resume_run", 32'(state), 32'd1);
    tick(5);
    chk("resume_ce", 32'(cpu_ce), 32'd1);
    chk("resume_cnt", inst_cnt, 32'd8);
    tick(5);
    chk("resume_brk", 32'(state), 32'd3);
    chk("resume_brk_ce", 32'(cpu_ce), 32'd0);

    // reset while a tick is pending under stall
    run_sw = 1'b0;
    tick(1);
    bp_en = 1'b0; run_sw = 1'b1;
    tick(4);
    cpu_stall = 1'b1;
    tick(3);
    chk("pend_run", 32'(state), 32'd1);
    reset = 1'b0; run_sw = 1'b0;
    tick(1);
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_ce", 32'(cpu_ce), 32'd0);
    chk("abort_cnt", inst_cnt, 32'd0);
    chk("abort_halted", 32'(halted), 32'd1);
    reset = 1'b1; cpu_stall = 1'b0;
    base = ce_seen;
    tick(8);
    chk("abort_no_ce", 32'(ce_seen - base), 32'd0);
    chk("abort_cnt_hold", inst_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run/step/breakpoint controller for the single-cycle CPU dataflow on the board.
- Replaces the free-running divided CPU clock with a one-cycle clock-enable (cpu_ce) in the clk_in domain.
- Supports continuous run at a programmable rate, debounced single-step, PC breakpoint, and stall hold-off.
- Keeps a retired-instruction counter for the 7-segment display mux.

Parameters:
- DIV, 10000000, clk_in cycles between cpu_ce pulses in RUN; legal range ≥ 2.
- DB_CYCLES, 1000000, clk_in cycles step_btn must hold a new level before that level is accepted; legal range ≥ 1.
- PC_W, 32, width of pc and bp_addr.

Ports:
- clk_in  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- run_sw  in  1  level switch: 1 = run, 0 = halt.
- step_btn  in  1  raw push-button; asynchronous, bouncing.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  PC_W  breakpoint PC.
- pc  in  PC_W  current CPU PC.
- cpu_stall  in  1  CPU stall request; holds off cpu_ce.
- cpu_ce  out  1  one-cycle CPU clock-enable; each pulse retires one instruction.
- state  out  2  controller state: 0 IDLE, 1 RUN, 2 STEP, 3 BRK.
- halted  out  1  high in IDLE and BRK.
- inst_cnt  out  32  count of cpu_ce pulses; wraps 2^32-1 → 0.

Behaviour:
- Reset, sampled when reset=0 on a clk_in edge:
  - state=IDLE, cpu_ce=0, halted=1, inst_cnt=0.
  - Tick counter=0, pending=0, bp_skip=0, debouncer cleared to stable-low.
- step_btn path:
  - 2-flop synchronizer, then debouncer.
  - step_pulse is a single clk_in-cycle pulse, issued DB_CYCLES cycles after the synchronized input first stays high continuously.
  - Release also requires DB_CYCLES stable cycles before another press is recognized.
  - Holding the button yields exactly one pulse.
- Tick counter:
  - Runs only in RUN; counts 0..DIV-1; clears on entering RUN.
  - Wrap sets pending=1.
- cpu_ce is registered and asserted for exactly one cycle when pending=1 and cpu_stall=0; pending clears in the same cycle.
- If cpu_stall=1, pending holds. cpu_ce fires on the first cycle after cpu_stall falls. Ticks that arrive while pending is already set are dropped, never queued.
- inst_cnt increments in the cycle cpu_ce=1.
- Breakpoint hit = bp_en & (pc==bp_addr) & ~bp_skip, evaluated when cpu_ce would otherwise fire.
  - A hit suppresses cpu_ce, clears pending, and moves to BRK.
- State transitions, evaluated top-down, first match wins:
  - IDLE:
    - run_sw=1 → RUN.
    - else step_pulse → STEP (pending=1).
  - RUN:
    - run_sw=0 → IDLE; pending cleared, no cpu_ce.
    - breakpoint hit → BRK.
    - Each issued cpu_ce clears bp_skip.
  - STEP:
    - When cpu_ce issues → IDLE if run_sw=0, else → RUN.
    - The breakpoint is ignored in STEP.
    - run_sw changes while in STEP do not abort the step.
  - BRK:
    - step_pulse → STEP, with bp_skip=1.
    - run_sw=0 → IDLE, with bp_skip=1.
    - Otherwise hold. cpu_ce stays 0 regardless of cpu_stall.
- bp_skip makes resuming from a breakpoint PC advance past it. It stays set until the next cpu_ce.
- step_pulse in RUN is ignored.
- Reset during any state, including a pending stall-held tick, aborts to the reset values on that edge with no cpu_ce.
- Latency:
  - IDLE step_pulse → cpu_ce is 2 cycles (STEP entry, then registered ce), given cpu_stall=0.
  - RUN entry → first cpu_ce is DIV+1 cycles.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - State encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_STEP=2'd2, ST_BRK=2'd3.
  - Also used by the seg display mux to show state.
- One sub-module: btn_debounce (parameter DB_CYCLES; ports clk_in, reset, btn_raw, pulse). Contains the synchronizer, stability counter and rising-edge pulse.

Test Plan (DIV=4, DB_CYCLES=3):
- Reset, run_sw=1, stall=0, bp_en=0 → state=RUN; first cpu_ce 5 cycles after RUN entry, then one pulse every 4 cycles; inst_cnt=3 after 3 pulses.
- IDLE, step_btn high for 10 cycles with bounce (1,0,1 in first 3 cycles) → exactly one step_pulse; exactly one cpu_ce; state STEP→IDLE; inst_cnt +1.
- RUN with cpu_stall=1 for 9 cycles starting at a tick → cpu_ce withheld; one cpu_ce in the first cycle after stall falls; inst_cnt +1 only.
- RUN, bp_en=1, bp_addr=0x0000_0010, pc driven to 0x10 → next tick gives BRK, no cpu_ce, halted=1. A step press yields one cpu_ce with pc still 0x10, then RUN (run_sw=1).
- BRK → run_sw=0 → IDLE; run_sw=1 with pc=0x10 → first tick issues cpu_ce (bp_skip); pc held at 0x10 on the next tick → BRK again.
- Reset asserted while pending and stall=1 in RUN → next cycle state=IDLE, cpu_ce=0, inst_cnt=0; no cpu_ce after stall falls.
